// File: rtl/moore_stream_ctrl.sv
// moore_stream_ctrl: serializes a valid/ready word stream MSB-first into a Moore detector and counts its hits per frame.
// Define MSTRM_FIRST_HIT_EN to add first_hit_vld/first_hit_pos (bit index of the first counted hit).
module moore_stream_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8,
    parameter int POS_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              det_in,
    output logic              det_rst,
    input  logic              det_out,
    output logic [CNT_W-1:0]  match_count,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
`ifdef MSTRM_FIRST_HIT_EN
    ,
    output logic              first_hit_vld,
    output logic [POS_W-1:0]  first_hit_pos
`endif
);
    localparam int BW = $clog2(WORD_W);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

    if (WORD_W < 2 || CNT_W < 1 || POS_W < 1) begin : g_param_chk
        $error("moore_stream_ctrl: invalid parameters");
    end

    logic [1:0]        state;
    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     bit_cnt;
    logic              last_q, smp, accept, hit;

    assign word_ready = (state == IDLE) || (state == SHIFT && bit_cnt == '0 && !last_q);
    assign accept     = word_valid && word_ready;
    // smp delays the SHIFT flag by one cycle to match the detector's output latency
    assign hit        = smp && det_out && (match_count != '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            last_q      <= 1'b0;
            smp         <= 1'b0;
            det_in      <= 1'b0;
            det_rst     <= 1'b1;
            match_count <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            smp        <= (state == SHIFT);
            frame_done <= 1'b0;
            if (hit) match_count <= match_count + 1'b1;
            if (accept) begin
                sreg    <= {word_data[WORD_W-2:0], 1'b0};
                det_in  <= word_data[WORD_W-1];
                bit_cnt <= BW'(WORD_W - 1);
                last_q  <= word_last;
            end
            case (state)
                IDLE: if (accept) begin
                    state       <= SHIFT;
                    det_rst     <= 1'b0;
                    busy        <= 1'b1;
                    match_count <= '0;
                    frame_err   <= 1'b0;
                end
                SHIFT: if (bit_cnt != '0) begin
                    sreg    <= {sreg[WORD_W-2:0], 1'b0};
                    det_in  <= sreg[WORD_W-1];
                    bit_cnt <= bit_cnt - 1'b1;
                end else if (!accept) begin
                    state     <= DRAIN;
                    det_in    <= 1'b0;
                    frame_err <= !last_q;
                end
                DRAIN: begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    det_rst <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MSTRM_FIRST_HIT_EN
    logic [POS_W-1:0] pos_cnt;

    // pos_cnt is one ahead of the bit whose result is being sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_cnt       <= '0;
            first_hit_vld <= 1'b0;
            first_hit_pos <= '0;
        end else begin
            if (state == SHIFT) pos_cnt <= pos_cnt + 1'b1;
            if (smp && det_out && !first_hit_vld) begin
                first_hit_vld <= 1'b1;
                first_hit_pos <= pos_cnt - 1'b1;
            end
            if (state == IDLE && accept) begin
                pos_cnt       <= '0;
                first_hit_vld <= 1'b0;
                first_hit_pos <= '0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_moore_stream_ctrl.sv
// tb_moore_stream_ctrl: random frames against a frame-level bitstream model, with a 1011 overlapping detector as load.
module tb_moore_stream_ctrl;
    localparam int W = 8, CW = 3, PW = 16, CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst, word_valid, word_last, word_ready, det_in, det_rst, det_out;
    logic frame_done, frame_err, busy;
    logic [W-1:0]  word_data;
    logic [CW-1:0] match_count;
`ifdef MSTRM_FIRST_HIT_EN
    logic          first_hit_vld;
    logic [PW-1:0] first_hit_pos;
`endif

    moore_stream_ctrl #(.WORD_W(W), .CNT_W(CW), .POS_W(PW)) dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .det_in(det_in), .det_rst(det_rst), .det_out(det_out),
        .match_count(match_count), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
`ifdef MSTRM_FIRST_HIT_EN
        , .first_hit_vld(first_hit_vld), .first_hit_pos(first_hit_pos)
`endif
    );

    always #5 clk = ~clk;

    logic [3:0] hist = '0;
    always @(posedge clk) hist <= det_rst ? 4'b0 : {hist[2:0], det_in};
    assign det_out = (hist == 4'b1011);

    int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0, done_at = -1;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] fw[16];
    int  fnw, k, L;
    bit  fuf, uflag, in_frame = 0;
    bit  fbits[$];
    int  prev_cnt = 0, prev_err = 0, prev_fv = 0, prev_fp = 0;

    function automatic bit is_match(int j);
        return j >= 3 && fbits[j-3] && !fbits[j-2] && fbits[j-1] && fbits[j];
    endfunction

    // hit ending at bit j becomes visible in match_count during cycle j+3 after accept
    function automatic int cnt_upto(int kk);
        int c = 0;
        for (int j = 0; j < L; j++) if (is_match(j) && j + 3 <= kk) c++;
        return c > CMAX ? CMAX : c;
    endfunction

    function automatic int first_j(int kk);
        for (int j = 0; j < L; j++) if (is_match(j) && j + 3 <= kk) return j;
        return -1;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, a, e);
        end
    endtask

    logic e_busy, e_drst, e_ready, e_din, e_done, e_err;
    int   e_cnt, e_fv, e_fp, fj;
    always @(negedge clk) begin
        if (in_frame) begin
            e_busy  = 1'b1;
            e_drst  = 1'b0;
            e_ready = (k <= L) && (k % W == 0) && !(k == L && !uflag);
            e_din   = (k <= L) ? fbits[k-1] : 1'b0;
            e_done  = (k == L + 2);
            e_err   = (k > L) && uflag;
            e_cnt   = cnt_upto(k);
            fj      = first_j(k);
            e_fv    = (fj >= 0);
            e_fp    = (fj >= 0) ? fj : 0;
        end else begin
            e_busy = 1'b0; e_drst = 1'b1; e_ready = 1'b1; e_din = 1'b0; e_done = 1'b0;
            e_err = prev_err[0]; e_cnt = prev_cnt; e_fv = prev_fv; e_fp = prev_fp;
        end
        chk("busy", busy, e_busy);
        chk("det_rst", det_rst, e_drst);
        chk("word_ready", word_ready, e_ready);
        chk("det_in", det_in, e_din);
        chk("frame_done", frame_done, e_done);
        chk("frame_err", frame_err, e_err);
        chk("match_count", match_count, e_cnt);
`ifdef MSTRM_FIRST_HIT_EN
        chk("first_hit_vld", first_hit_vld, e_fv);
        chk("first_hit_pos", first_hit_pos, e_fp);
`endif
        if (frame_done === 1'b1) done_at = cyc - acc_cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        word_valid = 1'b0;
        repeat (n) begin
            word_data = W'($urandom);
            word_last = 1'($urandom);
            step();
        end
    endtask

    // caller sits in an IDLE cycle; rst_at>0 aborts the frame with a reset in that cycle
    task automatic run_frame(input int rst_at);
        int pre[16];
        int i;
        L = fnw * W;
        uflag = fuf;
        done_at = -1;
        fbits.delete();
        for (int w = 0; w < fnw; w++) for (int b = W - 1; b >= 0; b--) fbits.push_back(fw[w][b]);
        for (int w = 1; w < fnw; w++) pre[w] = $urandom_range(w * W, (w - 1) * W + 1);
        word_valid = 1'b1;
        word_data  = fw[0];
        word_last  = (fnw == 1) && !fuf;
        step();
        acc_cyc  = cyc - 1;
        in_frame = 1'b1;
        for (int kk = 1; kk <= L + 2; kk++) begin
            k = kk;
            i = (kk + W - 1) / W;
            if (i >= 1 && i < fnw && kk >= pre[i]) begin
                word_valid = 1'b1;
                word_data  = fw[i];
                word_last  = (i == fnw - 1) && !fuf;
            end else begin
                word_valid = 1'b0;
                word_data  = W'($urandom);
                word_last  = 1'($urandom);
            end
            if (kk == rst_at) begin
                rst = 1'b1;
                in_frame = 1'b0;
                {prev_cnt, prev_err, prev_fv, prev_fp} = '0;
                word_valid = 1'b0;
                step();
                step();
                rst = 1'b0;
                return;
            end
            step();
        end
        in_frame = 1'b0;
        word_valid = 1'b0;
        prev_cnt = cnt_upto(L + 2);
        prev_err = uflag;
        fj = first_j(L + 2);
        prev_fv = (fj >= 0);
        prev_fp = (fj >= 0) ? fj : 0;
    endtask

    logic [W-1:0] pool[4] = '{8'hB6, 8'hBB, 8'h0B, 8'h2D};

    initial begin
        rst = 1'b1; word_valid = 1'b0; word_data = '0; word_last = 1'b0;
        step();
        step();
        rst = 1'b0;
        idle(1);
        fw[0] = 8'hB6; fnw = 1; fuf = 0; run_frame(0);
        chk("lit_b6_cnt", match_count, 2);
        chk("lit_b6_err", frame_err, 0);
        chk("lit_b6_done_cycle", done_at, 10);
        chk("lit_b6_det_rst", det_rst, 1);
`ifdef MSTRM_FIRST_HIT_EN
        chk("lit_b6_fh_vld", first_hit_vld, 1);
        chk("lit_b6_fh_pos", first_hit_pos, 3);
`endif
        fw[0] = 8'hB0; fw[1] = 8'hB0; fnw = 2; fuf = 0; run_frame(0);
        chk("lit_b0b0_cnt", match_count, 2);
        chk("lit_b0b0_done_cycle", done_at, 18);
        fw[0] = 8'hFF; fnw = 1; fuf = 1; run_frame(0);
        chk("lit_underrun_err", frame_err, 1);
        chk("lit_underrun_cnt", match_count, 0);
        chk("lit_underrun_done_cycle", done_at, 10);
        idle(2);
        fw[0] = 8'hB6; fnw = 1; fuf = 0; run_frame(0);
        chk("lit_clean_err", frame_err, 0);
        for (int w = 0; w < 4; w++) fw[w] = 8'hBB;
        fnw = 3; run_frame(0);
        chk("lit_bb3_cnt", match_count, 6);
        fnw = 4; run_frame(0);
        chk("lit_bb4_sat", match_count, CMAX);
        fw[0] = 8'hB6; fnw = 1; run_frame(5);
        chk("lit_rst_cnt", match_count, 0);
        chk("lit_rst_busy", busy, 0);
        run_frame(0);
        chk("lit_after_rst_cnt", match_count, 2);
        fw[0] = 8'h00; run_frame(0);
        chk("lit_zero_cnt", match_count, 0);
`ifdef MSTRM_FIRST_HIT_EN
        chk("lit_zero_fh_vld", first_hit_vld, 0);
`endif
        for (int f = 0; f < 60; f++) begin
            fnw = $urandom_range(1, 4);
            for (int w = 0; w < fnw; w++) fw[w] = $urandom_range(0, 1) ? pool[$urandom_range(0, 3)] : W'($urandom);
            fuf = ($urandom_range(0, 3) == 0);
            run_frame(($urandom_range(0, 7) == 0) ? $urandom_range(1, fnw * W + 2) : 0);
            idle($urandom_range(0, 2));
        end
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/moore_stream_ctrl.md
Name: moore_stream_ctrl

Overview:
Frame-level controller that feeds a single-bit Moore sequence detector (ports clk/rst/in/out, one-cycle state-to-output latency, no enable) from a parallel word stream.
Accepts words over a valid/ready handshake and serializes them MSB-first onto the detector input.
Holds the detector in reset between frames, counts detector hits per frame, and flags frame completion or underrun.
Sits between the word-producing datapath and the moore_overlapping instance.

Parameters:
WORD_W, 8, bits per input word (>=2)
CNT_W, 8, width of match counter (saturating)
POS_W, 16, width of bit-position counter used by optional feature

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
word_valid  input  1  upstream word available
word_data  input  WORD_W  word to serialize, MSB sent first
word_last  input  1  word is final word of frame (qualified by word_valid)
word_ready  output  1  controller accepts word this cycle
det_in  output  1  serial bit to detector "in"
det_rst  output  1  registered reset to detector "rst"
det_out  input  1  detector "out"
match_count  output  CNT_W  hits in current/last frame
frame_done  output  1  one-cycle pulse at end of frame
frame_err  output  1  underrun flag for last frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, word_ready=1, det_in=0, det_rst=1, match_count=0, frame_done=0, frame_err=0, busy=0, shift reg and bit counter=0.
- FSM states: IDLE, SHIFT, DRAIN, DONE. All outputs registered except word_ready (combinational from state/bit counter).
- IDLE: det_rst=1, word_ready=1. On word_valid&word_ready: load shift reg, bit_cnt=WORD_W-1, latch last flag, clear match_count and frame_err, det_rst<=0, go SHIFT.
- SHIFT: det_in = shift reg MSB; shift left each cycle; bit_cnt decrements. word_ready=1 only when bit_cnt==0 and latched last==0.
- Word boundary at bit_cnt==0, not last, word_valid=1: reload, stay SHIFT. No bubble between words.
- At bit_cnt==0, latched last=1: go DRAIN.
- At bit_cnt==0, not last, word_valid=0: underrun. frame_err<=1, go DRAIN. The frame is aborted; the controller never stalls mid-frame because the detector has no enable.
- Hit sampling: registered flag smp = (state==SHIFT) from previous cycle. When smp=1 and det_out=1, match_count increments, saturating at 2^CNT_W-1. det_out during the first SHIFT cycle is not counted.
- DRAIN: one cycle. Samples the result of the final bit, det_in=0, go DONE.
- DONE: frame_done=1 for one cycle, det_rst<=1, go IDLE. word_ready=0 in DRAIN/DONE.
- match_count and frame_err stay stable from DONE until the next frame's first handshake.
- Latency: N-word frame = N*WORD_W SHIFT cycles + DRAIN + DONE. frame_done is high in cycle N*WORD_W+2 after the first accept edge.
- rst asserted mid-frame: immediate return to reset values, detector re-held in reset, partial count discarded, no frame_done.
- word_valid while busy and word_ready=0: ignored; upstream must hold.

Optional Feature:
MSTRM_FIRST_HIT_EN: adds outputs first_hit_vld (1) and first_hit_pos (POS_W).
- A bit counter runs from 0 at frame start.
- On the first counted hit, it captures the 0-based index of the bit that completed the match and sets first_hit_vld.
- Both are cleared at frame start and reset to 0.
- Without the macro: ports absent, no position counter logic.

Test Plan:
Detector pattern 1011 overlapping, WORD_W=8 unless noted:
- Single word 0xB6, last=1 -> match_count=2, frame_err=0, frame_done pulse in 10th cycle after accept, det_rst high again after DONE.
- Two words 0xB0 then 0xB0 (second last=1), valid held -> word_ready high exactly in 8th bit cycle, no gap in det_in, match_count=2, done at cycle 18.
- Word 0xFF last=0, no follow-up valid -> frame_err=1, match_count=0, frame_done pulse, return to IDLE; next clean frame clears frame_err.
- CNT_W=2, three words 0xBB (last on third) -> 6 hits saturate, match_count=3.
- rst pulsed at bit 4 of 0xB6 frame -> all outputs at reset values, no frame_done; a following 0xB6 frame gives match_count=2.
- With MSTRM_FIRST_HIT_EN, frame 0xB6 -> first_hit_vld=1, first_hit_pos=3; frame 0x00 -> first_hit_vld=0.
